dcw_rx_checker: RTL and testbench
=================================

// Module: dcw_rx_checker
// PURPOSE
//  Receive-side counterpart of the data channel wrapper: the DCW drives ref_clock,
//  channel_reset and datawidth to the TX lane; this block consumes the same three
//  signals on the RX lane. It samples the serial RX bit on each ref_clock rising edge,
//  frames words of the programmed width, and checks them against PRBS7 (x^7+x^6+1).
//  It reports lock, bit errors and bits compared to the IBERT status logic.
// PARAMETERS
//  CNT_W     32  width of bit_cnt / bit_err_cnt (both saturate at all-ones)
//  LOCK_CNT   8  consecutive error-free words in HUNT to declare lock (>=1)
//  LOSS_CNT   4  consecutive errored words in LOCKED to drop lock (>=1)
// PORTS
//  clock          in   1      system clock; all logic on posedge
//  reset_n        in   1      asynchronous active-low reset
//  ref_clock      in   1      DCW-generated reference clock, treated as async level
//  channel_reset  in   1      1 = hold channel in IDLE, clear counters
//  datawidth      in   3      word length code: W = 4*(datawidth+1) bits (4..32)
//  rx_bit         in   1      serial RX data, valid around ref_clock rising edge
//  locked         out  1      1 while state == LOCKED
//  state          out  2      0 IDLE, 1 SEED, 2 HUNT, 3 LOCKED
//  word_done      out  1      1-cycle pulse at end of each checked word (HUNT/LOCKED)
//  word_err       out  1      1-cycle pulse with word_done if word had >=1 bit error
//  bit_cnt        out  CNT_W  bits compared while LOCKED, saturating
//  bit_err_cnt    out  CNT_W  bit mismatches while LOCKED, saturating
// BEHAVIOUR
//  Reset: async on reset_n low -> state IDLE, all outputs 0, lfsr 0, sync flops 0.
//  Sampling: ref_clock and rx_bit each pass a 2-flop synchronizer; strobe = ref_s2 & ~ref_s3
//   (one cycle per rising edge); on strobe the bit used is rx_s2. Latency: bit affects
//   state/counters 3 clock edges after ref_clock rises. ref_clock >= 4 clocks per period.
//  IDLE: entered whenever channel_reset=1 (synchronous, highest priority, any state);
//   clears bit_cnt, bit_err_cnt, word/bit indices, good/bad run counters. When
//   channel_reset=0 -> SEED next cycle, latching datawidth into wlen; datawidth changes
//   after that are ignored until next IDLE.
//  SEED: each strobe lfsr <= {lfsr[5:0], bit}; after 7 strobes -> HUNT, bit index=0.
//   If the 7 seeded bits are all 0, stay in SEED and reseed (all-zero lock forbidden).
//  HUNT/LOCKED: each strobe: pred = lfsr[6]^lfsr[5]; err = bit^pred;
//   lfsr <= {lfsr[5:0], bit} (self-synchronising, uses received bit). Bit index counts
//   0..W-1; at index W-1: word_done=1, word_err=(any err in word incl. this bit), wrap to 0.
//  HUNT: errored word -> good run=0, back to SEED; error-free word -> good run+1;
//   good run == LOCK_CNT -> LOCKED (transition at that word_done), bad run=0.
//  LOCKED: each strobe bit_cnt+1, bit_err_cnt+err (both saturate, never wrap).
//   Errored word -> bad run+1, clean word -> bad run=0; bad run == LOSS_CNT -> SEED,
//   counters keep values (cleared only by channel_reset or reset_n).
//  Simultaneous: channel_reset with strobe -> IDLE wins, strobe discarded. Strobe on
//   the cycle of leaving IDLE is discarded (SEED starts from the next strobe).
//  word_done/word_err pulse exactly one clock, only when strobe; 0 in IDLE/SEED.
// TESTING
//  1 reset_n low mid-LOCKED -> all outputs 0, state IDLE immediately (async).
//  2 datawidth=1 (W=8), clean PRBS7 from seed 7'h7F -> SEED 7 strobes, locked after
//    8 words (71 strobes total), then bit_cnt=+8 per word_done, bit_err_cnt=0.
//  3 Locked, W=8, flip 1 bit -> word_err once, bit_err_cnt=3 (self-sync triples the
//    error: pred uses bad bit twice); 4 consecutive flipped words -> state SEED, locked=0.
//  4 channel_reset pulsed while LOCKED with counters non-zero -> IDLE, counters 0;
//    change datawidth to 7 during LOCKED -> W stays 8 until channel_reset.
//  5 All-zero rx_bit stream -> remains in SEED indefinitely, locked=0, counters 0.
//  6 CNT_W=4, force errors -> bit_err_cnt saturates at 4'hF, bit_cnt at 4'hF, no wrap.

Source files
------------

// File: rtl/dcw_rx_checker.sv
// PRBS7 receive checker for the DCW RX lane: samples rx_bit on ref_clock rising
// edges, frames words of the latched width, hunts for lock and counts bit errors.
module dcw_rx_checker #(
  parameter int CNT_W    = 32,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ref_clock,
  input  logic             channel_reset,
  input  logic [2:0]       datawidth,
  input  logic             rx_bit,
  output logic             locked,
  output logic [1:0]       state,
  output logic             word_done,
  output logic             word_err,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    HUNT   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  logic ref_s1_q, ref_s2_q, ref_s3_q;
  logic rx_s1_q, rx_s2_q;
  logic strobe;

  state_t             state_q, state_d;
  logic [6:0]         lfsr_q, lfsr_d;
  logic [2:0]         wlen_q, wlen_d;
  logic [2:0]         seed_idx_q, seed_idx_d;
  logic [4:0]         bit_idx_q, bit_idx_d;
  logic               werr_q, werr_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [BAD_W-1:0]   bad_q, bad_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   bit_err_cnt_q, bit_err_cnt_d;
  logic               word_done_q, word_done_d;
  logic               word_err_q, word_err_d;

  logic               pred, err, last, word_bad;
  logic [6:0]         shifted;
  logic [GOOD_W-1:0]  good_inc;
  logic [BAD_W-1:0]   bad_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ref_s1_q <= 1'b0;
      ref_s2_q <= 1'b0;
      ref_s3_q <= 1'b0;
      rx_s1_q  <= 1'b0;
      rx_s2_q  <= 1'b0;
    end else begin
      ref_s1_q <= ref_clock;
      ref_s2_q <= ref_s1_q;
      ref_s3_q <= ref_s2_q;
      rx_s1_q  <= rx_bit;
      rx_s2_q  <= rx_s1_q;
    end
  end

  assign strobe   = ref_s2_q & ~ref_s3_q;
  assign pred     = lfsr_q[6] ^ lfsr_q[5];
  assign err      = rx_s2_q ^ pred;
  assign shifted  = {lfsr_q[5:0], rx_s2_q};
  assign last     = (bit_idx_q == {wlen_q, 2'b11});
  assign word_bad = werr_q | err;
  assign good_inc = good_q + GOOD_W'(1);
  assign bad_inc  = bad_q + BAD_W'(1);

  // The predictor always shifts in the received bit, so a single flipped bit
  // shows up as three mismatches before it leaves the register.
  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    wlen_d        = wlen_q;
    seed_idx_d    = seed_idx_q;
    bit_idx_d     = bit_idx_q;
    werr_d        = werr_q;
    good_d        = good_q;
    bad_d         = bad_q;
    bit_cnt_d     = bit_cnt_q;
    bit_err_cnt_d = bit_err_cnt_q;
    word_done_d   = 1'b0;
    word_err_d    = 1'b0;

    if (channel_reset) begin
      state_d       = IDLE;
      seed_idx_d    = '0;
      bit_idx_d     = '0;
      werr_d        = 1'b0;
      good_d        = '0;
      bad_d         = '0;
      bit_cnt_d     = '0;
      bit_err_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = SEED;
          wlen_d     = datawidth;
          seed_idx_d = '0;
        end
        SEED: begin
          if (strobe) begin
            lfsr_d = shifted;
            if (seed_idx_q == 3'd6) begin
              seed_idx_d = '0;
              if (shifted != 7'd0) begin
                state_d   = HUNT;
                bit_idx_d = '0;
                werr_d    = 1'b0;
                good_d    = '0;
              end
            end else begin
              seed_idx_d = seed_idx_q + 3'd1;
            end
          end
        end
        default: begin
          if (strobe) begin
            lfsr_d = shifted;
            if (state_q == LOCKED) begin
              if (!(&bit_cnt_q)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
              if (err && !(&bit_err_cnt_q)) bit_err_cnt_d = bit_err_cnt_q + CNT_W'(1);
            end
            if (last) begin
              bit_idx_d   = '0;
              werr_d      = 1'b0;
              word_done_d = 1'b1;
              word_err_d  = word_bad;
              if (state_q == HUNT) begin
                if (word_bad) begin
                  state_d    = SEED;
                  seed_idx_d = '0;
                  good_d     = '0;
                end else if (good_inc == GOOD_W'(LOCK_CNT)) begin
                  state_d = LOCKED;
                  good_d  = '0;
                  bad_d   = '0;
                end else begin
                  good_d = good_inc;
                end
              end else begin
                if (!word_bad) begin
                  bad_d = '0;
                end else if (bad_inc == BAD_W'(LOSS_CNT)) begin
                  state_d    = SEED;
                  seed_idx_d = '0;
                  bad_d      = '0;
                end else begin
                  bad_d = bad_inc;
                end
              end
            end else begin
              bit_idx_d = bit_idx_q + 5'd1;
              werr_d    = word_bad;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lfsr_q        <= '0;
      wlen_q        <= '0;
      seed_idx_q    <= '0;
      bit_idx_q     <= '0;
      werr_q        <= 1'b0;
      good_q        <= '0;
      bad_q         <= '0;
      bit_cnt_q     <= '0;
      bit_err_cnt_q <= '0;
      word_done_q   <= 1'b0;
      word_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      wlen_q        <= wlen_d;
      seed_idx_q    <= seed_idx_d;
      bit_idx_q     <= bit_idx_d;
      werr_q        <= werr_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_err_cnt_q <= bit_err_cnt_d;
      word_done_q   <= word_done_d;
      word_err_q    <= word_err_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign state       = state_q;
  assign word_done   = word_done_q;
  assign word_err    = word_err_q;
  assign bit_cnt     = bit_cnt_q;
  assign bit_err_cnt = bit_err_cnt_q;

endmodule

// File: tb/tb_dcw_rx_checker.sv
// Directed bench for dcw_rx_checker: a full-width instance and a 4-bit-counter
// instance share one stimulus stream of PRBS7 bits clocked by a slow ref_clock.
module tb_dcw_rx_checker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ref_clock;
  logic        channel_reset;
  logic [2:0]  datawidth;
  logic        rx_bit;

  logic        locked, lockedS;
  logic [1:0]  state, stateS;
  logic        word_done, word_doneS;
  logic        word_err, word_errS;
  logic [31:0] bit_cnt, bit_err_cnt;
  logic [3:0]  bit_cntS, bit_err_cntS;

  int          checks = 0;
  int          errors = 0;
  int          wdCount = 0;
  int          weCount = 0;
  logic [6:0]  gen;

  dcw_rx_checker #(.CNT_W(32), .LOCK_CNT(8), .LOSS_CNT(4)) dut (
    .clock(clock), .reset_n(reset_n), .ref_clock(ref_clock),
    .channel_reset(channel_reset), .datawidth(datawidth), .rx_bit(rx_bit),
    .locked(locked), .state(state), .word_done(word_done), .word_err(word_err),
    .bit_cnt(bit_cnt), .bit_err_cnt(bit_err_cnt)
  );

  dcw_rx_checker #(.CNT_W(4), .LOCK_CNT(8), .LOSS_CNT(4)) dutSmall (
    .clock(clock), .reset_n(reset_n), .ref_clock(ref_clock),
    .channel_reset(channel_reset), .datawidth(datawidth), .rx_bit(rx_bit),
    .locked(lockedS), .state(stateS), .word_done(word_doneS), .word_err(word_errS),
    .bit_cnt(bit_cntS), .bit_err_cnt(bit_err_cntS)
  );

  always #5 clock = ~clock;

  // Pulses last one full clock, so each is seen at exactly one falling edge.
  always @(negedge clock) begin
    if (word_done) wdCount <= wdCount + 1;
    if (word_err)  weCount <= weCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic sendBit(input logic b);
    @(negedge clock);
    rx_bit    = b;
    ref_clock = 1'b1;
    repeat (4) @(negedge clock);
    ref_clock = 1'b0;
    repeat (4) @(negedge clock);
    #1;
  endtask

  task automatic nextPrbs(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  task automatic applyStimulus(input int nBits, input bit flipFirst);
    logic b;
    for (int i = 0; i < nBits; i++) begin
      nextPrbs(b);
      if (flipFirst && (i % 8 == 0)) b = ~b;
      sendBit(b);
    end
  endtask

  task automatic sendSeed();
    gen = 7'h7F;
    for (int i = 0; i < 7; i++) sendBit(1'b1);
  endtask

  task automatic pulseChannelReset(input logic [2:0] dw);
    @(negedge clock);
    channel_reset = 1'b1;
    repeat (2) @(negedge clock);
    datawidth = dw;
    checkOutput("idle_state", 32'(state), 32'd0);
    checkOutput("idle_bit_cnt", bit_cnt, 32'd0);
    checkOutput("idle_err_cnt", bit_err_cnt, 32'd0);
    channel_reset = 1'b0;
    @(negedge clock);
    checkOutput("seed_after_idle", 32'(state), 32'd1);
  endtask

  initial begin
    int wdBase;
    reset_n       = 1'b0;
    ref_clock     = 1'b0;
    channel_reset = 1'b0;
    datawidth     = 3'd1;
    rx_bit        = 1'b0;
    gen           = 7'h7F;
    #12;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_bit_cnt", bit_cnt, 32'd0);
    checkOutput("rst_word_done", 32'(word_done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("seed_after_rst", 32'(state), 32'd1);

    $display("[TB] lock acquisition at W=8");
    sendSeed();
    checkOutput("hunt_after_seed", 32'(state), 32'd2);
    applyStimulus(63, 1'b0);
    checkOutput("hunt_before_lock", 32'(state), 32'd2);
    checkOutput("words_before_lock", 32'(wdCount), 32'd7);
    applyStimulus(1, 1'b0);
    checkOutput("locked_state", 32'(state), 32'd3);
    checkOutput("locked_flag", 32'(locked), 32'd1);
    checkOutput("lock_bit_cnt", bit_cnt, 32'd0);
    checkOutput("lock_word_err", 32'(weCount), 32'd0);

    applyStimulus(16, 1'b0);
    checkOutput("clean_bit_cnt", bit_cnt, 32'd16);
    checkOutput("clean_err_cnt", bit_err_cnt, 32'd0);
    checkOutput("clean_words", 32'(wdCount), 32'd10);
    checkOutput("small_bit_cnt_sat", 32'(bit_cntS), 32'd15);

    $display("[TB] single flipped bit while locked");
    applyStimulus(8, 1'b1);
    checkOutput("flip_word_err", 32'(weCount), 32'd1);
    checkOutput("flip_err_cnt", bit_err_cnt, 32'd3);
    checkOutput("flip_bit_cnt", bit_cnt, 32'd24);
    applyStimulus(8, 1'b0);
    checkOutput("flip_still_locked", 32'(state), 32'd3);
    checkOutput("flip_err_stable", bit_err_cnt, 32'd3);

    for (int p = 0; p < 5; p++) begin
      applyStimulus(8, 1'b1);
      applyStimulus(8, 1'b0);
    end
    checkOutput("alt_err_cnt", bit_err_cnt, 32'd18);
    checkOutput("alt_bit_cnt", bit_cnt, 32'd112);
    checkOutput("alt_locked", 32'(state), 32'd3);
    checkOutput("small_err_sat", 32'(bit_err_cntS), 32'd15);

    $display("[TB] datawidth change while locked is ignored");
    datawidth = 3'd7;
    wdBase = wdCount;
    applyStimulus(8, 1'b0);
    checkOutput("dw_ignored_words", 32'(wdCount - wdBase), 32'd1);
    checkOutput("dw_ignored_bits", bit_cnt, 32'd120);

    $display("[TB] four errored words drop lock");
    applyStimulus(24, 1'b1);
    checkOutput("loss_after3", 32'(state), 32'd3);
    applyStimulus(8, 1'b1);
    checkOutput("loss_state", 32'(state), 32'd1);
    checkOutput("loss_locked", 32'(locked), 32'd0);
    checkOutput("loss_err_cnt", bit_err_cnt, 32'd30);
    checkOutput("loss_bit_cnt", bit_cnt, 32'd152);
    checkOutput("loss_word_errs", 32'(weCount), 32'd10);
    checkOutput("small_err_hold", 32'(bit_err_cntS), 32'd15);

    $display("[TB] channel_reset relatches width W=32");
    pulseChannelReset(3'd7);
    sendSeed();
    checkOutput("w32_hunt", 32'(state), 32'd2);
    wdBase = wdCount;
    applyStimulus(31, 1'b0);
    checkOutput("w32_no_done_yet", 32'(wdCount - wdBase), 32'd0);
    applyStimulus(1, 1'b0);
    checkOutput("w32_done", 32'(wdCount - wdBase), 32'd1);

    $display("[TB] all-zero stream stays in SEED");
    pulseChannelReset(3'd1);
    wdBase = wdCount;
    for (int i = 0; i < 20; i++) sendBit(1'b0);
    checkOutput("zero_state", 32'(state), 32'd1);
    checkOutput("zero_locked", 32'(locked), 32'd0);
    checkOutput("zero_words", 32'(wdCount - wdBase), 32'd0);
    checkOutput("zero_bit_cnt", bit_cnt, 32'd0);

    $display("[TB] async reset while locked");
    pulseChannelReset(3'd1);
    sendSeed();
    applyStimulus(64, 1'b0);
    checkOutput("relock_state", 32'(state), 32'd3);
    applyStimulus(8, 1'b0);
    checkOutput("relock_bit_cnt", bit_cnt, 32'd8);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_state", 32'(state), 32'd0);
    checkOutput("async_locked", 32'(locked), 32'd0);
    checkOutput("async_bit_cnt", bit_cnt, 32'd0);
    checkOutput("async_small_cnt", 32'(bit_cntS), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
